// File: rtl/sv_rq_pkg.sv
// rtl/sv_rq_pkg.sv - shared types and width helpers for the random-word request sequencer
package sv_rq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } fsm_state_t;

    // Counter width for a range of v values, never narrower than one bit
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sv_rq_arb_rr_arbiter.sv
// rtl/sv_rq_arb_rr_arbiter.sv - combinational round-robin pick starting at ptr_i
module rr_arbiter
    import sv_rq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                req_i,
    input  logic [clog2_min1(N)-1:0]    ptr_i,
    output logic [N-1:0]                gnt_o,
    output logic [clog2_min1(N)-1:0]    idx_o,
    output logic                        any_o
);

    localparam int PW = clog2_min1(N);

    int j;

    // Walk from the farthest offset down so the request closest to ptr_i wins last
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr_i) + i) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sv_rq_arb.sv
// rtl/sv_rq_arb.sv - multi-client RNG word sequencer with round-robin grant and timeout/retry
module sv_rq_arb
    import sv_rq_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int DATA_WIDTH = 512,
    parameter int RND_WIDTH  = 64,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [CH_NUM-1:0]     req_v_i,
    output logic [CH_NUM-1:0]     req_ready_o,
    output logic [CH_NUM-1:0]     rsp_v_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  rng_u_o,
    input  logic                  rng_r_i,
    input  logic [RND_WIDTH-1:0]  rng_data_i,
    output logic                  busy_o
);

    localparam int WORDS = DATA_WIDTH / RND_WIDTH;
    localparam int PW    = clog2_min1(CH_NUM);
    localparam int TW    = clog2_min1(TIMEOUT);
    localparam int RTW   = clog2_min1(MAX_RETRY + 1);
    localparam int WW    = clog2_min1(WORDS);

    fsm_state_t            state_q;
    logic [CH_NUM-1:0]     pending_q, pending_d;
    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         gnt_idx_q;
    logic [CH_NUM-1:0]     gnt_oh_q;
    logic [WW-1:0]         word_cnt_q;
    logic [RTW-1:0]        retry_q;
    logic [TW-1:0]         tmo_cnt_q;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [CH_NUM-1:0]     rsp_v_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rng_u_q;

    logic [CH_NUM-1:0]     arb_gnt;
    logic [PW-1:0]         arb_idx;
    logic                  arb_any;
    logic [PW-1:0]         ptr_next;

    // A request from a ready client is taken directly, so it can win in the same IDLE cycle
    rr_arbiter #(.N(CH_NUM)) u_arb (
        .req_i (pending_q | req_v_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign ptr_next = (int'(arb_idx) == CH_NUM - 1) ? '0 : arb_idx + PW'(1);

    always_comb begin
        pending_d = pending_q | req_v_i;
        if (state_q == DONE || state_q == ERR) begin
            pending_d[gnt_idx_q] = 1'b0;
        end
    end

    always_comb begin
        asm_d = asm_q;
        asm_d[int'(word_cnt_q) * RND_WIDTH +: RND_WIDTH] = rng_data_i;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_oh_q   <= '0;
            word_cnt_q <= '0;
            retry_q    <= '0;
            tmo_cnt_q  <= '0;
            asm_q      <= '0;
            rsp_v_q    <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            rng_u_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rng_u_q   <= 1'b0;
            rsp_v_q   <= '0;
            rsp_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gnt_idx_q  <= arb_idx;
                        gnt_oh_q   <= arb_gnt;
                        ptr_q      <= ptr_next;
                        word_cnt_q <= '0;
                        retry_q    <= '0;
                        rng_u_q    <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (rng_r_i) begin
                        asm_q   <= asm_d;
                        retry_q <= '0;
                        if (word_cnt_q == WW'(WORDS - 1)) begin
                            rsp_v_q    <= gnt_oh_q;
                            rsp_data_q <= asm_d;
                            state_q    <= DONE;
                        end else begin
                            word_cnt_q <= word_cnt_q + WW'(1);
                            rng_u_q    <= 1'b1;
                            state_q    <= REQ;
                        end
                    end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                        if (int'(retry_q) < MAX_RETRY) begin
                            retry_q <= retry_q + RTW'(1);
                            rng_u_q <= 1'b1;
                            state_q <= REQ;
                        end else begin
                            rsp_v_q    <= gnt_oh_q;
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= '0;
                            state_q    <= ERR;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                DONE, ERR: state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = ~pending_q;
    assign rsp_v_o     = rsp_v_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_data_o  = rsp_data_q;
    assign rng_u_o     = rng_u_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_sv_rq_arb.sv
// tb/tb_sv_rq_arb.sv - directed bench for sv_rq_arb with an auto-answering RNG stand-in
module tb_sv_rq_arb;

    logic         clk = 1'b0;
    logic         areset;
    logic [3:0]   req_v_i;
    logic [3:0]   req_ready_o;
    logic [3:0]   rsp_v_o;
    logic [511:0] rsp_data_o;
    logic         rsp_err_o;
    logic         rng_u_o;
    logic         rng_r_i;
    logic [63:0]  rng_data_i;
    logic         busy_o;

    int tests = 0;
    int fails = 0;

    int           pulses;
    int           consec;
    int           widx = 0;
    int           pulse_cyc[$];
    int           rsp_cyc[$];
    logic [3:0]   rsp_ch[$];
    logic         rsp_er[$];
    logic [511:0] rsp_dat[$];

    always #5 clk = ~clk;

    sv_rq_arb #(
        .CH_NUM(4), .DATA_WIDTH(512), .RND_WIDTH(64), .TIMEOUT(4), .MAX_RETRY(2)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .req_v_i     (req_v_i),
        .req_ready_o (req_ready_o),
        .rsp_v_o     (rsp_v_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .rng_u_o     (rng_u_o),
        .rng_r_i     (rng_r_i),
        .rng_data_i  (rng_data_i),
        .busy_o      (busy_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] exp_data(input int base);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*64 +: 64] = 64'(base + k);
        return r;
    endfunction

    // Cycle 0 carries req0; each rng_u_o pulse is answered in the next cycle unless its
    // index is set in ignore. spurious drives rng_r_i in the request cycles and cycle 0.
    task automatic run(input logic [3:0] req0, input int ncyc, input logic [31:0] ignore,
                       input bit spurious, input int abort_at, input int midc, input logic [3:0] midv);
        bit answer;
        bit prev_u;
        answer = 1'b0;
        prev_u = 1'b0;
        pulses = 0;
        consec = 0;
        pulse_cyc.delete();
        rsp_cyc.delete();
        rsp_ch.delete();
        rsp_er.delete();
        rsp_dat.delete();
        req_v_i    = req0;
        rng_r_i    = spurious;
        rng_data_i = 64'hDEAD;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            req_v_i = (c == midc) ? midv : 4'b0;
            rng_r_i = 1'b0;
            if (answer) begin
                rng_r_i    = 1'b1;
                rng_data_i = 64'(widx);
                widx++;
            end
            answer = 1'b0;
            if (rsp_v_o != 4'b0) begin
                rsp_cyc.push_back(c);
                rsp_ch.push_back(rsp_v_o);
                rsp_er.push_back(rsp_err_o);
                rsp_dat.push_back(rsp_data_o);
            end
            if (rng_u_o) begin
                if (prev_u) consec++;
                pulse_cyc.push_back(c);
                if (!ignore[pulses]) answer = 1'b1;
                pulses++;
                if (spurious && !rng_r_i) begin
                    rng_r_i    = 1'b1;
                    rng_data_i = 64'hDEAD;
                end
                if (pulses == abort_at) return;
            end
            prev_u = rng_u_o;
        end
        rng_r_i = 1'b0;
    endtask

    initial begin
        areset     = 1'b0;
        req_v_i    = '0;
        rng_r_i    = 1'b0;
        rng_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  busy_o,      1'b0);
        chk("rst_ready", req_ready_o, 4'hF);
        chk("rst_rspv",  rsp_v_o,     4'h0);
        chk("rst_data",  rsp_data_o,  '0);
        chk("rst_err",   rsp_err_o,   1'b0);
        chk("rst_rngu",  rng_u_o,     1'b0);
        step();
        areset = 1'b1;
        step();

        // Single request on ch0, RNG answers at once
        run(4'b0001, 22, 32'h0, 1'b0, 0, 0, 4'b0);
        chk("t1_pulses", pulses, 8);
        chk("t1_consec", consec, 0);
        chk("t1_nrsp",   rsp_cyc.size(), 1);
        if (pulse_cyc.size() == 8) begin
            chk("t1_p0cyc", pulse_cyc[0], 1);
            chk("t1_p7cyc", pulse_cyc[7], 15);
        end
        if (rsp_cyc.size() > 0) begin
            chk("t1_cyc",  rsp_cyc[0], 17);
            chk("t1_ch",   rsp_ch[0],  4'b0001);
            chk("t1_err",  rsp_er[0],  1'b0);
            chk("t1_data", rsp_dat[0], exp_data(0));
        end
        chk("t1_hold",  rsp_data_o,  exp_data(0));
        chk("t1_ready", req_ready_o, 4'hF);
        chk("t1_busy",  busy_o,      1'b0);

        // ch1..3 together, ch0 joins mid-stream
        run(4'b1110, 80, 32'h0, 1'b0, 0, 5, 4'b0001);
        chk("t2_nrsp", rsp_cyc.size(), 4);
        if (rsp_cyc.size() == 4) begin
            chk("t2_ch0", rsp_ch[0], 4'b0010);
            chk("t2_ch1", rsp_ch[1], 4'b0100);
            chk("t2_ch2", rsp_ch[2], 4'b1000);
            chk("t2_ch3", rsp_ch[3], 4'b0001);
            chk("t2_gap", rsp_cyc[1] - rsp_cyc[0], 18);
            chk("t2_d1",  rsp_dat[1], exp_data(16));
            chk("t2_d3",  rsp_dat[3], exp_data(32));
            chk("t2_err", {rsp_er[0], rsp_er[1], rsp_er[2], rsp_er[3]}, 4'b0);
        end

        // Silent RNG: three pulses five cycles apart, then an error response
        run(4'b0100, 25, 32'hFFFF_FFFF, 1'b0, 0, 0, 4'b0);
        chk("t3_pulses", pulses, 3);
        if (pulse_cyc.size() == 3) begin
            chk("t3_p1", pulse_cyc[1], 6);
            chk("t3_p2", pulse_cyc[2], 11);
        end
        chk("t3_nrsp", rsp_cyc.size(), 1);
        if (rsp_cyc.size() > 0) begin
            chk("t3_cyc",  rsp_cyc[0], 16);
            chk("t3_ch",   rsp_ch[0],  4'b0100);
            chk("t3_err",  rsp_er[0],  1'b1);
            chk("t3_data", rsp_dat[0], '0);
        end

        // One retry on word 0, two on word 1: succeeds only if retry restarts per word
        run(4'b1000, 40, 32'b1101, 1'b0, 0, 0, 4'b0);
        chk("t4_pulses", pulses, 11);
        chk("t4_nrsp",   rsp_cyc.size(), 1);
        if (rsp_cyc.size() > 0) begin
            chk("t4_cyc",  rsp_cyc[0], 32);
            chk("t4_err",  rsp_er[0],  1'b0);
            chk("t4_data", rsp_dat[0], exp_data(40));
        end

        // rng_r_i in IDLE and REQ cycles has no effect
        rng_r_i    = 1'b1;
        rng_data_i = 64'hBEEF;
        step();
        step();
        chk("t5_idle_rngu", rng_u_o, 1'b0);
        chk("t5_idle_busy", busy_o,  1'b0);
        run(4'b0001, 22, 32'h0, 1'b1, 0, 0, 4'b0);
        chk("t5_pulses", pulses, 8);
        chk("t5_nrsp",   rsp_cyc.size(), 1);
        if (rsp_cyc.size() > 0) begin
            chk("t5_cyc",  rsp_cyc[0], 17);
            chk("t5_data", rsp_dat[0], exp_data(48));
        end

        // Reset while waiting on word 4
        run(4'b0010, 30, 32'h0, 1'b0, 5, 0, 4'b0);
        chk("t6_pulses", pulses, 5);
        step();
        chk("t6_pre_busy", busy_o, 1'b1);
        #2;
        areset = 1'b0;
        #1;
        chk("t6_busy",  busy_o,      1'b0);
        chk("t6_ready", req_ready_o, 4'hF);
        chk("t6_data",  rsp_data_o,  '0);
        chk("t6_rspv",  rsp_v_o,     4'h0);
        chk("t6_rngu",  rng_u_o,     1'b0);
        step();
        areset = 1'b1;
        run(4'b0000, 30, 32'h0, 1'b0, 0, 0, 4'b0);
        chk("t6_after_rsp",   rsp_cyc.size(), 0);
        chk("t6_after_pulse", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
